// File: rtl/count_seq_checker_if.sv
// Count-checker bus: stimulus from the producer side, verdicts from the checker.
interface count_seq_checker_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TALLY_W = 16
);
  logic               enable;
  logic               cnt_rst;
  logic [WIDTH-1:0]   count_in;
  logic [WIDTH-1:0]   expected;
  logic               mismatch;
  logic [TALLY_W-1:0] match_count;
  logic [TALLY_W-1:0] err_count;
  logic               done;
  logic [1:0]         state;

  modport master (
    output enable, cnt_rst, count_in,
    input  expected, mismatch, match_count, err_count, done, state
  );

  modport slave (
    input  enable, cnt_rst, count_in,
    output expected, mismatch, match_count, err_count, done, state
  );
endinterface

// File: rtl/count_seq_checker.sv
// Monitors a free-running count bus: checks +1 per cycle, tallies matches/errors,
// resynchronises after a glitch and flags when the programmed target value is seen.
module count_seq_checker #(
  parameter int unsigned     WIDTH   = 32,
  parameter longint unsigned TARGET  = 5,
  parameter int unsigned     TALLY_W = 16
) (
  input logic               clk,
  input logic               reset,
  count_seq_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    TRACK = 2'b10,
    DONE  = 2'b11
  } state_t;

  // A target outside the representable count range can never be reached.
  localparam bit TGT_OK = (WIDTH >= 64) || (TARGET < (64'd1 << WIDTH));
  localparam logic [WIDTH-1:0] TGT = WIDTH'(TARGET);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic               mismatch_q, mismatch_d;
  logic [TALLY_W-1:0] match_q, match_d;
  logic [TALLY_W-1:0] err_q, err_d;
  logic               done_q, done_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      expected_q <= '0;
      mismatch_q <= 1'b0;
      match_q    <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      mismatch_q <= mismatch_d;
      match_q    <= match_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    mismatch_d = 1'b0;
    match_d    = match_q;
    err_d      = err_q;
    done_d     = done_q;

    if (!bus.enable) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = SYNC;

        SYNC: begin
          state_d    = TRACK;
          expected_d = bus.cnt_rst ? '0 : bus.count_in + WIDTH'(1);
        end

        TRACK: begin
          if (bus.cnt_rst) begin
            expected_d = '0;
          end else if (bus.count_in == expected_q) begin
            match_d    = (match_q == '1) ? match_q : match_q + TALLY_W'(1);
            expected_d = expected_q + WIDTH'(1);
            if (TGT_OK && (bus.count_in == TGT)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            // Resync on the observed value so one glitch costs exactly one error.
            mismatch_d = 1'b1;
            err_d      = (err_q == '1) ? err_q : err_q + TALLY_W'(1);
            expected_d = bus.count_in + WIDTH'(1);
          end
        end

        DONE: begin
          done_d = 1'b1;
          if (bus.cnt_rst) begin
            state_d    = TRACK;
            expected_d = '0;
            done_d     = 1'b0;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.expected    = expected_q;
  assign bus.mismatch    = mismatch_q;
  assign bus.match_count = match_q;
  assign bus.err_count   = err_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: default build, a 4-bit wrap build and a 2-bit tally build.
module tb_count_seq_checker;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  count_seq_checker_if #(.WIDTH(32), .TALLY_W(16)) b0 ();
  count_seq_checker_if #(.WIDTH(4),  .TALLY_W(16)) b1 ();
  count_seq_checker_if #(.WIDTH(8),  .TALLY_W(2))  b2 ();

  count_seq_checker #(.WIDTH(32), .TARGET(5),  .TALLY_W(16)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  count_seq_checker #(.WIDTH(4),  .TARGET(99), .TALLY_W(16)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  count_seq_checker #(.WIDTH(8),  .TARGET(5),  .TALLY_W(2))  dut2 (.clk(clk), .reset(reset), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    b0.enable = 1'b0; b0.cnt_rst = 1'b0; b0.count_in = '0;
    b1.enable = 1'b0; b1.cnt_rst = 1'b0; b1.count_in = '0;
    b2.enable = 1'b0; b2.cnt_rst = 1'b0; b2.count_in = '0;
    tick(); tick();
    n_checks++;
    if (b0.state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %0h want 0", b0.state); end
    n_checks++;
    if (b0.expected !== 32'd0 || b0.mismatch !== 1'b0 || b0.done !== 1'b0)
      begin n_fail++; $display("FAIL reset_outs got exp=%0h mm=%0b done=%0b want 0/0/0", b0.expected, b0.mismatch, b0.done); end
    n_checks++;
    if (b0.match_count !== 16'd0 || b0.err_count !== 16'd0)
      begin n_fail++; $display("FAIL reset_tally got %0d/%0d want 0/0", b0.match_count, b0.err_count); end
    reset = 1'b1;
  endtask

  task automatic test_basic_run();
    b0.enable = 1'b1;
    tick();
    n_checks++;
    if (b0.state !== 2'b01) begin n_fail++; $display("FAIL t1_sync got %0h want 1", b0.state); end
    b0.count_in = 32'd0;
    tick();
    n_checks++;
    if (b0.state !== 2'b10 || b0.expected !== 32'd1 || b0.match_count !== 16'd0)
      begin n_fail++; $display("FAIL t1_track got st=%0h exp=%0d mc=%0d want 2/1/0", b0.state, b0.expected, b0.match_count); end
    for (int i = 1; i <= 5; i++) begin
      b0.count_in = 32'(i);
      tick();
    end
    n_checks++;
    if (b0.state !== 2'b11 || b0.done !== 1'b1)
      begin n_fail++; $display("FAIL t1_done got st=%0h done=%0b want 3/1", b0.state, b0.done); end
    n_checks++;
    if (b0.match_count !== 16'd5 || b0.err_count !== 16'd0 || b0.expected !== 32'd6)
      begin n_fail++; $display("FAIL t1_tally got mc=%0d ec=%0d exp=%0d want 5/0/6", b0.match_count, b0.err_count, b0.expected); end
    // count_in ignored while DONE
    b0.count_in = 32'd77;
    tick();
    n_checks++;
    if (b0.state !== 2'b11 || b0.done !== 1'b1 || b0.err_count !== 16'd0 || b0.mismatch !== 1'b0)
      begin n_fail++; $display("FAIL t1_hold got st=%0h done=%0b ec=%0d want 3/1/0", b0.state, b0.done, b0.err_count); end
  endtask

  task automatic test_restart();
    b0.cnt_rst = 1'b1;
    tick();
    b0.cnt_rst = 1'b0;
    n_checks++;
    if (b0.state !== 2'b10 || b0.done !== 1'b0 || b0.expected !== 32'd0)
      begin n_fail++; $display("FAIL t2_rst got st=%0h done=%0b exp=%0d want 2/0/0", b0.state, b0.done, b0.expected); end
    b0.count_in = 32'd0;
    tick();
    n_checks++;
    if (b0.expected !== 32'd1 || b0.mismatch !== 1'b0)
      begin n_fail++; $display("FAIL t2_c0 got exp=%0d mm=%0b want 1/0", b0.expected, b0.mismatch); end
    b0.count_in = 32'd1;
    tick();
    n_checks++;
    if (b0.expected !== 32'd2 || b0.mismatch !== 1'b0 || b0.match_count !== 16'd7)
      begin n_fail++; $display("FAIL t2_c1 got exp=%0d mm=%0b mc=%0d want 2/0/7", b0.expected, b0.mismatch, b0.match_count); end
  endtask

  task automatic test_glitch();
    logic [31:0] seq [5];
    seq[0] = 32'd2; seq[1] = 32'd3; seq[2] = 32'd4; seq[3] = 32'd7; seq[4] = 32'd8;
    for (int i = 0; i < 4; i++) begin
      b0.count_in = seq[i];
      tick();
    end
    n_checks++;
    if (b0.mismatch !== 1'b1 || b0.err_count !== 16'd1 || b0.expected !== 32'd8)
      begin n_fail++; $display("FAIL t3_glitch got mm=%0b ec=%0d exp=%0d want 1/1/8", b0.mismatch, b0.err_count, b0.expected); end
    b0.count_in = seq[4];
    tick();
    n_checks++;
    if (b0.mismatch !== 1'b0 || b0.expected !== 32'd9 || b0.match_count !== 16'd11 || b0.err_count !== 16'd1)
      begin n_fail++; $display("FAIL t3_resync got mm=%0b exp=%0d mc=%0d ec=%0d want 0/9/11/1", b0.mismatch, b0.expected, b0.match_count, b0.err_count); end
  endtask

  task automatic test_disable_and_reset();
    b0.enable = 1'b0;
    b0.count_in = 32'd50;
    tick();
    n_checks++;
    if (b0.state !== 2'b00 || b0.match_count !== 16'd11 || b0.err_count !== 16'd1 || b0.expected !== 32'd9)
      begin n_fail++; $display("FAIL t6_disable got st=%0h mc=%0d ec=%0d exp=%0d want 0/11/1/9", b0.state, b0.match_count, b0.err_count, b0.expected); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    b0.enable = 1'b1;
    tick();
    for (int i = 0; i <= 3; i++) begin
      b0.count_in = 32'(i);
      tick();
    end
    n_checks++;
    if (b0.state !== 2'b10 || b0.match_count !== 16'd3)
      begin n_fail++; $display("FAIL t6_pre got st=%0h mc=%0d want 2/3", b0.state, b0.match_count); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++;
    if (b0.state !== 2'b00 || b0.match_count !== 16'd0 || b0.err_count !== 16'd0 || b0.expected !== 32'd0 || b0.done !== 1'b0 || b0.mismatch !== 1'b0)
      begin n_fail++; $display("FAIL t6_reset got st=%0h mc=%0d ec=%0d exp=%0d want all 0", b0.state, b0.match_count, b0.err_count, b0.expected); end
    b0.enable = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] seq [4];
    seq[0] = 4'd14; seq[1] = 4'd15; seq[2] = 4'd0; seq[3] = 4'd1;
    b1.enable = 1'b1;
    tick();
    b1.count_in = 4'd13;
    tick();
    for (int i = 0; i < 4; i++) begin
      b1.count_in = seq[i];
      tick();
      n_checks++;
      if (b1.mismatch !== 1'b0 || b1.done !== 1'b0)
        begin n_fail++; $display("FAIL t4_wrap_step%0d got mm=%0b done=%0b want 0/0", i, b1.mismatch, b1.done); end
    end
    n_checks++;
    if (b1.match_count !== 16'd4 || b1.err_count !== 16'd0 || b1.expected !== 4'd2 || b1.state !== 2'b10)
      begin n_fail++; $display("FAIL t4_wrap got mc=%0d ec=%0d exp=%0d st=%0h want 4/0/2/2", b1.match_count, b1.err_count, b1.expected, b1.state); end
    b1.enable = 1'b0;
  endtask

  task automatic test_back_to_back_errors();
    logic [7:0] seq [4];
    logic [1:0] want_ec [4];
    seq[0] = 8'd20; seq[1] = 8'd30; seq[2] = 8'd40; seq[3] = 8'd50;
    want_ec[0] = 2'd1; want_ec[1] = 2'd2; want_ec[2] = 2'd3; want_ec[3] = 2'd3;
    b2.enable = 1'b1;
    tick();
    b2.count_in = 8'd10;
    tick();
    for (int i = 0; i < 4; i++) begin
      b2.count_in = seq[i];
      tick();
      n_checks++;
      if (b2.mismatch !== 1'b1 || b2.err_count !== want_ec[i])
        begin n_fail++; $display("FAIL t5_err%0d got mm=%0b ec=%0d want 1/%0d", i, b2.mismatch, b2.err_count, want_ec[i]); end
    end
    b2.count_in = 8'd51;
    tick();
    n_checks++;
    if (b2.mismatch !== 1'b0 || b2.err_count !== 2'd3 || b2.match_count !== 2'd1)
      begin n_fail++; $display("FAIL t5_after got mm=%0b ec=%0d mc=%0d want 0/3/1", b2.mismatch, b2.err_count, b2.match_count); end
    b2.enable = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_run();
    test_restart();
    test_glitch();
    test_disable_and_reset();
    test_wrap();
    test_back_to_back_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
